if_fetch_unit: RTL and testbench

- Instruction fetch stage; the producer side of the IF/ID pipeline register.
- Owns the PC and drives a Wishbone-classic master to instruction memory.
- Presents PC + instruction + valid to the IF/ID register.
- Honours the shared flush_and_stall control and branch redirects from later stages.

---
 rtl/pipeline_pkg.sv | 20 ++
 rtl/if_fetch_unit.sv | 208 ++++++++++++++++++++
 tb/tb_if_fetch_unit.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline control encodings and constants
package pipeline_pkg;

    // Shared flush_and_stall encoding; 2'b11 is not named and behaves as FETCH.
    typedef enum logic [1:0] {
        FETCH = 2'b00,
        STALL = 2'b01,
        FLUSH = 2'b10
    } flush_stall_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        HOLD = 2'b10
    } fetch_state_t;

    localparam logic [31:0] BUBBLE_INST = 32'h0000_0000;
    localparam int unsigned PC_STEP     = 4;

endpackage

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage: PC, Wishbone-classic fetch master, IF/ID producer
//
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   flush_and_stall              00 fetch, 01 stall, 10 flush, 11 fetch
//   redirect_i, redirect_pc_i    taken branch/jump pulse and its target
//   wb_cyc_o/stb_o/adr_o/sel_o/we_o, wb_dat_i/ack_i   read-only Wishbone-classic master
//   PC_addr, instruction, if_valid_o                  presented instruction to IF/ID
module if_fetch_unit
    import pipeline_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] PC_ADDR    = 32'h8000_0000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              flush_and_stall,
    input  logic                    redirect_i,
    input  logic [ADDR_WIDTH-1:0]   redirect_pc_i,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    output logic                    wb_we_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic                    wb_ack_i,
    output logic [ADDR_WIDTH-1:0]   PC_addr,
    output logic [DATA_WIDTH-1:0]   instruction,
    output logic                    if_valid_o
);

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic                  bus_q, bus_d;
    logic [ADDR_WIDTH-1:0] pc_addr_q, pc_addr_d;
    logic [DATA_WIDTH-1:0] inst_q, inst_d;
    logic                  valid_q, valid_d;
    logic                  pend_q, pend_d;
    logic                  stall_seen_q, stall_seen_d;
    logic                  skid_valid_q, skid_valid_d;
    logic [ADDR_WIDTH-1:0] skid_pc_q, skid_pc_d;
    logic [DATA_WIDTH-1:0] skid_inst_q, skid_inst_d;

    logic                  stall;
    logic                  flush;
    logic [ADDR_WIDTH-1:0] target;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic                  unused_redirect_low;

    assign stall   = (flush_and_stall == STALL);
    assign flush   = (flush_and_stall == FLUSH);
    assign target  = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
    assign pc_next = pc_q + ADDR_WIDTH'(PC_STEP);
    assign unused_redirect_low = ^redirect_pc_i[1:0];

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        adr_d        = adr_q;
        bus_d        = bus_q;
        pc_addr_d    = pc_addr_q;
        inst_d       = inst_q;
        valid_d      = valid_q;
        pend_d       = pend_q;
        stall_seen_d = 1'b0;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_inst_d  = skid_inst_q;

        // Redirect and flush both turn the presented slot into a bubble and
        // drop any parked word; PC_addr is left alone.
        if (redirect_i || flush) begin
            valid_d      = 1'b0;
            inst_d       = DATA_WIDTH'(BUBBLE_INST);
            skid_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                state_d = REQ;
                bus_d   = 1'b1;
                if (redirect_i) begin
                    pc_d  = target;
                    adr_d = target;
                end else begin
                    adr_d = pc_q;
                end
            end

            HOLD: begin
                if (redirect_i) begin
                    pc_d    = target;
                    adr_d   = target;
                    bus_d   = 1'b1;
                    state_d = REQ;
                end else if (!stall) begin
                    adr_d   = pc_q;
                    bus_d   = 1'b1;
                    state_d = REQ;
                    if (skid_valid_q && !flush) begin
                        pc_addr_d    = skid_pc_q;
                        inst_d       = skid_inst_q;
                        valid_d      = 1'b1;
                        skid_valid_d = 1'b0;
                    end
                end
            end

            REQ: begin
                if (!wb_ack_i) begin
                    // The bus transaction is never aborted; a redirect only
                    // retargets the PC and marks the in-flight word as stale.
                    stall_seen_d = stall;
                    if (redirect_i) begin
                        pend_d = 1'b1;
                        pc_d   = target;
                    end
                end else begin
                    pend_d = 1'b0;
                    bus_d  = 1'b0;
                    if (redirect_i) begin
                        pc_d    = target;
                        adr_d   = target;
                        bus_d   = 1'b1;
                        state_d = REQ;
                    end else if (pend_q || flush) begin
                        // Stale or flushed word: refetch from pc_q, which already
                        // holds the redirect target or the unadvanced address.
                        if (stall) begin
                            state_d = HOLD;
                        end else begin
                            adr_d   = pc_q;
                            bus_d   = 1'b1;
                            state_d = REQ;
                        end
                    end else begin
                        pc_d = pc_next;
                        // A stall that was already in force before the ack means
                        // the presented slot is frozen, so the word goes to the skid.
                        if (stall && stall_seen_q) begin
                            skid_valid_d = 1'b1;
                            skid_pc_d    = adr_q;
                            skid_inst_d  = wb_dat_i;
                        end else begin
                            pc_addr_d = adr_q;
                            inst_d    = wb_dat_i;
                            valid_d   = 1'b1;
                        end
                        if (stall) begin
                            state_d = HOLD;
                        end else begin
                            adr_d   = pc_next;
                            bus_d   = 1'b1;
                            state_d = REQ;
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
                bus_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= PC_ADDR;
            adr_q        <= '0;
            bus_q        <= 1'b0;
            pc_addr_q    <= '0;
            inst_q       <= '0;
            valid_q      <= 1'b0;
            pend_q       <= 1'b0;
            stall_seen_q <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= '0;
            skid_inst_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            adr_q        <= adr_d;
            bus_q        <= bus_d;
            pc_addr_q    <= pc_addr_d;
            inst_q       <= inst_d;
            valid_q      <= valid_d;
            pend_q       <= pend_d;
            stall_seen_q <= stall_seen_d;
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_inst_q  <= skid_inst_d;
        end
    end

    assign wb_cyc_o    = bus_q;
    assign wb_stb_o    = bus_q;
    assign wb_adr_o    = adr_q;
    assign wb_sel_o    = '1;
    assign wb_we_o     = 1'b0;
    assign PC_addr     = pc_addr_q;
    assign instruction = inst_q;
    assign if_valid_o  = valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed self-checking bench for if_fetch_unit
module tb_if_fetch_unit;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic [1:0]  fs;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        cyc, stb, we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        ack;
    logic [31:0] pc_addr;
    logic [31:0] inst;
    logic        valid;

    logic        mem_ack;
    logic        extra_ack;
    int          lat;
    int          cnt;
    int          checks;
    int          errors;

    if_fetch_unit dut (
        .clk             (clk),
        .reset           (rst),
        .flush_and_stall (fs),
        .redirect_i      (redirect),
        .redirect_pc_i   (redirect_pc),
        .wb_cyc_o        (cyc),
        .wb_stb_o        (stb),
        .wb_adr_o        (adr),
        .wb_sel_o        (sel),
        .wb_we_o         (we),
        .wb_dat_i        (dat),
        .wb_ack_i        (ack),
        .PC_addr         (pc_addr),
        .instruction     (inst),
        .if_valid_o      (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: word at address A reads as ~A; ack after lat edges of stb.
    assign dat = ~adr;
    assign ack = mem_ack | extra_ack;
    always @(posedge clk) begin
        if (rst || !(cyc && stb) || mem_ack) begin
            mem_ack <= 1'b0;
            cnt     <= 0;
        end else if (cnt >= lat - 1) begin
            mem_ack <= 1'b1;
            cnt     <= 0;
        end else begin
            cnt <= cnt + 1;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int latency);
        rst = 1'b1;
        fs = 2'b00;
        redirect = 1'b0;
        extra_ack = 1'b0;
        lat = latency;
        step(1);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        step(2);
        checks++;
        if ({cyc, stb, adr, pc_addr, inst, valid, sel, we} !== {1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 4'hF, 1'b0}) begin
            errors++;
            $display("FAIL reset_values got cyc=%b stb=%b adr=%h pc=%h inst=%h v=%b sel=%h we=%b", cyc, stb, adr, pc_addr, inst, valid, sel, we);
        end
    endtask

    task automatic test_fetch_stream;
        do_reset(1);
        step(1);
        checks++;
        if ({cyc, stb, adr} !== {1'b1, 1'b1, BASE}) begin
            errors++;
            $display("FAIL first_request got cyc=%b stb=%b adr=%h want 1 1 %h", cyc, stb, adr, BASE);
        end
        step(2);
        checks++;
        if ({valid, pc_addr, inst} !== {1'b1, 32'h8000_0000, 32'h7FFF_FFFF}) begin
            errors++;
            $display("FAIL stream_0 got v=%b pc=%h inst=%h want 1 80000000 7fffffff", valid, pc_addr, inst);
        end
        step(2);
        checks++;
        if ({valid, pc_addr, inst} !== {1'b1, 32'h8000_0004, 32'h7FFF_FFFB}) begin
            errors++;
            $display("FAIL stream_4 got v=%b pc=%h inst=%h want 1 80000004 7ffffffb", valid, pc_addr, inst);
        end
        step(2);
        checks++;
        if ({valid, pc_addr, inst} !== {1'b1, 32'h8000_0008, 32'h7FFF_FFF7}) begin
            errors++;
            $display("FAIL stream_8 got v=%b pc=%h inst=%h want 1 80000008 7ffffff7", valid, pc_addr, inst);
        end
    endtask

    task automatic test_stall;
        do_reset(1);
        step(4);
        checks++;
        if ({ack, adr} !== {1'b1, 32'h8000_0004}) begin
            errors++;
            $display("FAIL stall_setup got ack=%b adr=%h want 1 80000004", ack, adr);
        end
        fs = 2'b01;
        for (int i = 0; i < 5; i++) begin
            step(1);
            checks++;
            if ({cyc, stb, valid, pc_addr, inst} !== {1'b0, 1'b0, 1'b1, 32'h8000_0004, 32'h7FFF_FFFB}) begin
                errors++;
                $display("FAIL stall_frozen cycle %0d got cyc=%b stb=%b v=%b pc=%h inst=%h want 0 0 1 80000004 7ffffffb", i, cyc, stb, valid, pc_addr, inst);
            end
        end
        fs = 2'b00;
        step(1);
        checks++;
        if ({cyc, stb, adr} !== {1'b1, 1'b1, 32'h8000_0008}) begin
            errors++;
            $display("FAIL stall_release got cyc=%b stb=%b adr=%h want 1 1 80000008", cyc, stb, adr);
        end
    endtask

    task automatic test_skid;
        do_reset(3);
        step(2);
        fs = 2'b01;
        step(3);
        checks++;
        if ({cyc, valid, pc_addr, inst} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL skid_frozen got cyc=%b v=%b pc=%h inst=%h want 0 0 0 0", cyc, valid, pc_addr, inst);
        end
        step(1);
        fs = 2'b11;
        step(1);
        checks++;
        if ({valid, pc_addr, inst, cyc, adr} !== {1'b1, BASE, 32'h7FFF_FFFF, 1'b1, 32'h8000_0004}) begin
            errors++;
            $display("FAIL skid_release got v=%b pc=%h inst=%h cyc=%b adr=%h want 1 80000000 7fffffff 1 80000004", valid, pc_addr, inst, cyc, adr);
        end
    endtask

    task automatic test_redirect_pending;
        int n;
        logic bad;
        logic reached;
        do_reset(1);
        n = 0;
        while (!(cyc && adr == 32'h8000_0010 && !ack) && n < 20) begin
            step(1);
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL redirect_setup got adr=%h want 80000010 within 20 cycles", adr);
        end
        lat = 3;
        redirect = 1'b1;
        redirect_pc = 32'h8000_0103;
        step(1);
        redirect = 1'b0;
        checks++;
        if ({valid, inst, pc_addr, cyc, adr} !== {1'b0, 32'h0, 32'h8000_000C, 1'b1, 32'h8000_0010}) begin
            errors++;
            $display("FAIL redirect_invalidate got v=%b inst=%h pc=%h cyc=%b adr=%h want 0 0 8000000c 1 80000010", valid, inst, pc_addr, cyc, adr);
        end
        bad = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 12 && !reached; i++) begin
            step(1);
            if (valid && pc_addr == 32'h8000_0010) bad = 1'b1;
            if (cyc && adr == 32'h8000_0100) reached = 1'b1;
        end
        checks++;
        if ({bad, reached} !== 2'b01) begin
            errors++;
            $display("FAIL redirect_target got stale_seen=%b target_reached=%b want 0 1", bad, reached);
        end
        n = 0;
        while (!valid && n < 10) begin
            step(1);
            n++;
        end
        checks++;
        if ({valid, pc_addr, inst} !== {1'b1, 32'h8000_0100, 32'h7FFF_FEFF}) begin
            errors++;
            $display("FAIL redirect_word got v=%b pc=%h inst=%h want 1 80000100 7ffffeff", valid, pc_addr, inst);
        end
    endtask

    task automatic test_flush;
        do_reset(1);
        step(7);
        checks++;
        if ({valid, pc_addr} !== {1'b1, 32'h8000_0008}) begin
            errors++;
            $display("FAIL flush_setup got v=%b pc=%h want 1 80000008", valid, pc_addr);
        end
        fs = 2'b10;
        step(1);
        fs = 2'b00;
        checks++;
        if ({valid, inst, pc_addr} !== {1'b0, 32'h0, 32'h8000_0008}) begin
            errors++;
            $display("FAIL flush_bubble got v=%b inst=%h pc=%h want 0 0 80000008", valid, inst, pc_addr);
        end
        step(1);
        checks++;
        if ({valid, pc_addr, inst} !== {1'b1, 32'h8000_000C, 32'h7FFF_FFF3}) begin
            errors++;
            $display("FAIL flush_next got v=%b pc=%h inst=%h want 1 8000000c 7ffffff3", valid, pc_addr, inst);
        end
    endtask

    task automatic test_wrap;
        do_reset(1);
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        step(1);
        redirect = 1'b0;
        checks++;
        if ({cyc, adr} !== {1'b1, 32'hFFFF_FFFC}) begin
            errors++;
            $display("FAIL wrap_first_adr got cyc=%b adr=%h want 1 fffffffc", cyc, adr);
        end
        step(2);
        checks++;
        if ({valid, pc_addr, inst, adr} !== {1'b1, 32'hFFFF_FFFC, 32'h0000_0003, 32'h0}) begin
            errors++;
            $display("FAIL wrap_top got v=%b pc=%h inst=%h adr=%h want 1 fffffffc 00000003 00000000", valid, pc_addr, inst, adr);
        end
        step(2);
        checks++;
        if ({valid, pc_addr, inst} !== {1'b1, 32'h0, 32'hFFFF_FFFF}) begin
            errors++;
            $display("FAIL wrap_zero got v=%b pc=%h inst=%h want 1 00000000 ffffffff", valid, pc_addr, inst);
        end
    endtask

    task automatic test_reset_mid;
        do_reset(1);
        step(5);
        checks++;
        if ({cyc, valid, pc_addr} !== {1'b1, 1'b1, 32'h8000_0004}) begin
            errors++;
            $display("FAIL rst_mid_setup got cyc=%b v=%b pc=%h want 1 1 80000004", cyc, valid, pc_addr);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({cyc, stb, adr, pc_addr, inst, valid} !== {1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL rst_mid_async got cyc=%b stb=%b adr=%h pc=%h inst=%h v=%b want all 0", cyc, stb, adr, pc_addr, inst, valid);
        end
        @(negedge clk);
        rst = 1'b0;
        extra_ack = 1'b1;
        step(1);
        extra_ack = 1'b0;
        checks++;
        if ({cyc, adr, valid} !== {1'b1, BASE, 1'b0}) begin
            errors++;
            $display("FAIL rst_mid_restart got cyc=%b adr=%h v=%b want 1 80000000 0", cyc, adr, valid);
        end
        step(2);
        checks++;
        if ({valid, pc_addr, inst} !== {1'b1, BASE, 32'h7FFF_FFFF}) begin
            errors++;
            $display("FAIL rst_mid_first got v=%b pc=%h inst=%h want 1 80000000 7fffffff", valid, pc_addr, inst);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        fs = 2'b00;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        extra_ack = 1'b0;
        lat = 1;
        test_reset;
        test_fetch_stream;
        test_stall;
        test_skid;
        test_redirect_pending;
        test_flush;
        test_wrap;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
